ann_weight_loader: RTL
======================

# ann_weight_loader

Synthesizable loader that streams every weight of the three-layer Q-network from an external weight memory into the ANN weight-write port, layer by layer, bias last within each node. It replaces bench-side weight sequencing. It sits between the weight store (initial or target-network copy) and the `ann` core's `i_weight_valid/i_weight_layer/i_weight_addr/i_weight` inputs. It adds a layer-select mask, downstream backpressure, an abort, and start/busy/done handshaking.

## Interface
- DATA_WIDTH, 32, weight word width (IEEE-754 single)
- LAYER_WIDTH, 2, layer code width; codes 2'b01 hidden 1, 2'b10 hidden 2, 2'b11 output
- NUMBER_OF_INPUT_NODE, 2, fan-in of hidden layer 1
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, nodes in hidden 1; fan-in of hidden 2
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, nodes in hidden 2; fan-in of output
- NUMBER_OF_OUTPUT_NODE, 3, output nodes
- WEIGHT_COUNTER_WIDTH, 11, address width; must hold the largest layer size minus 1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request, sampled only in IDLE
- i_layer_mask  in  3  bit0 = hidden 1, bit1 = hidden 2, bit2 = output; sampled with i_start
- i_abort  in  1  terminate the current load
- o_mem_rd_en  out  1  weight-memory read strobe
- o_mem_layer  out  LAYER_WIDTH  layer code of the read
- o_mem_addr  out  WEIGHT_COUNTER_WIDTH  address of the read
- i_mem_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after o_mem_rd_en
- o_weight_valid  out  1  weight word available
- i_weight_ready  in  1  consumer accepts the word this cycle
- o_weight_layer  out  LAYER_WIDTH  layer code of the word
- o_weight_addr  out  WEIGHT_COUNTER_WIDTH  address of the word
- o_weight  out  DATA_WIDTH  weight word
- o_busy  out  1  high from start acceptance to done/abort
- o_done  out  1  one-cycle pulse after the last accepted word

## Operation
- Layer L has fan-in F: hidden 1 = NUMBER_OF_INPUT_NODE, hidden 2 = H1, output = H2. Each node holds F+1 weights.
- Address = node*(F+1) + w, for w = 0..F. w = F is the bias.
- Layer sizes at default parameters: 96, 1056 and 99 words.
- Layers are loaded in ascending code order. Masked-off layers are skipped.
- Inside a layer, addresses increment by 1 from 0 to size-1 with no gaps.
- FSM states:
  - IDLE: i_start=1 with mask≠0 moves to ISSUE at the first enabled layer and raises o_busy. i_start=1 with mask=0 moves to DONE.
  - ISSUE: issues reads. On the last address of a layer it moves to the next enabled layer, or to DRAIN if none remains.
  - DRAIN: waits until the buffer is empty and no read is in flight, then moves to DONE.
  - DONE: o_done=1 for one cycle, o_busy drops, then IDLE.
- Buffer: 2-entry FIFO holding {layer, addr, data}. The output fields show the head entry; o_weight_valid = FIFO not empty.
- A read is issued in cycle t only when (occupancy + reads in flight − pop at t) < 2. This guarantees the FIFO never overflows.
- Handshake: a word transfers when o_weight_valid && i_weight_ready. While valid and not ready, all o_weight_* outputs hold stable.
- i_start while busy is ignored.
- i_abort (any non-IDLE state): next cycle the FIFO is flushed, the in-flight read is discarded, o_weight_valid=0, o_busy=0, state=IDLE, and no o_done.
- i_abort has priority over a simultaneous handshake; that word is not considered delivered.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset mid-load behaves as abort, asynchronously.

## Timing
- Start accepted at edge 0. o_mem_rd_en=1 in cycle 1 (addr 0). Data captured at edge 2. o_weight_valid=1 in cycle 2.
- With i_weight_ready held 1: one word per cycle, no bubbles, including across layer boundaries.
- Full load of all three layers (1251 words) with ready=1: last handshake in cycle 1252, o_done in cycle 1253, o_busy low from cycle 1254.
- Ready deasserted for N cycles: at most 2 words are buffered and reads stall. After ready returns, throughput recovers to 1 word/cycle with zero lost or duplicated words.
- o_done fires exactly 1 cycle after the final handshake. Mask=0 gives o_done in cycle 1.

## Test plan
- Mask 3'b111, ready=1, memory word = {layer, addr} pattern: expect 1251 words in order: layer 1 addr 0..95, layer 2 addr 0..1055, layer 3 addr 0..98. Data must match the pattern, o_done in cycle 1253.
- Mask 3'b100: expect only the 99 output-layer words (addr 0..98, code 2'b11), o_done 1 cycle after the 99th transfer.
- Random ready (50%) on a full load: the word sequence must be identical to the ready=1 run. o_weight_* stays stable while valid && !ready, and o_mem_rd_en never fires while the FIFO plus in-flight reads hold 2.
- Assert i_abort at the layer-2 word with addr 500: the next cycle shows valid=0, busy=0, no o_done. A new i_start with mask 3'b010 then restarts cleanly from layer 2 addr 0.
- Mask 3'b000: o_done pulse in cycle 1, no o_mem_rd_en, no o_weight_valid. A second i_start pulsed mid-load is ignored, giving exactly one o_done.
- Assert rst at cycle 40 of a full load: all outputs 0 immediately (asynchronous). After release, idle until the next i_start.

Source files
------------

// File: rtl/ann_weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ann_weight_loader_if
// Brief    : Weight-memory read port and weight-write stream of the loader.
// Revision : 1.0
// ============================================================================
interface ann_weight_loader_if #(
  parameter int DATA_WIDTH           = 32,
  parameter int LAYER_WIDTH          = 2,
  parameter int WEIGHT_COUNTER_WIDTH = 11
);
  logic                            o_mem_rd_en;
  logic [LAYER_WIDTH-1:0]          o_mem_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0]           i_mem_data;
  logic                            o_weight_valid;
  logic                            i_weight_ready;
  logic [LAYER_WIDTH-1:0]          o_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr;
  logic [DATA_WIDTH-1:0]           o_weight;

  modport master (
    output o_mem_rd_en, o_mem_layer, o_mem_addr,
    input  i_mem_data,
    output o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
    input  i_weight_ready
  );

  modport slave (
    input  o_mem_rd_en, o_mem_layer, o_mem_addr,
    output i_mem_data,
    input  o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
    output i_weight_ready
  );
endinterface
`default_nettype wire

// File: rtl/ann_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : ann_weight_loader
// Brief    : Streams all Q-network weights from weight memory to the ANN port.
// Revision : 1.0
// ============================================================================
module ann_weight_loader #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [2:0]          i_layer_mask,
  input  logic                i_abort,
  ann_weight_loader_if.master bus,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] c_LAST_L1 = WEIGHT_COUNTER_WIDTH'(
    NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1) - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] c_LAST_L2 = WEIGHT_COUNTER_WIDTH'(
    NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1) - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] c_LAST_L3 = WEIGHT_COUNTER_WIDTH'(
    NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1) - 1);
  localparam logic [LAYER_WIDTH-1:0] c_L1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] c_L2 = LAYER_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Smallest enabled layer code strictly above cur; zero when none remains.
  function automatic logic [LAYER_WIDTH-1:0] next_layer(input logic [2:0] mask,
                                                        input logic [LAYER_WIDTH-1:0] cur);
    next_layer = '0;
    for (int k = 3; k >= 1; k--) begin
      if (mask[k-1] && (LAYER_WIDTH'(k) > cur)) next_layer = LAYER_WIDTH'(k);
    end
  endfunction

  state_t                          state_q, state_d;
  logic [2:0]                      mask_q, mask_d;
  logic [LAYER_WIDTH-1:0]          layer_q, layer_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] addr_q, addr_d;

  logic                            pend_q;
  logic [LAYER_WIDTH-1:0]          pend_layer_q;
  logic [WEIGHT_COUNTER_WIDTH-1:0] pend_addr_q;
  logic [LAYER_WIDTH-1:0]          fifo_layer_q [2];
  logic [WEIGHT_COUNTER_WIDTH-1:0] fifo_addr_q  [2];
  logic [DATA_WIDTH-1:0]           fifo_data_q  [2];
  logic                            wr_ptr_q, rd_ptr_q;
  logic [1:0]                      count_q;

  logic                            w_fifo_nempty, w_valid, w_pop, w_pop_fifo, w_push;
  logic                            w_issue, w_abort;
  logic [1:0]                      w_occ_next;
  logic [WEIGHT_COUNTER_WIDTH-1:0] w_layer_last;
  logic [LAYER_WIDTH-1:0]          w_next_layer;
  logic [LAYER_WIDTH-1:0]          w_head_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]           w_head_data;

  // A read in flight is visible at the output the cycle its data returns,
  // so an empty buffer costs no extra latency.
  assign w_fifo_nempty = (count_q != 2'd0);
  assign w_valid       = w_fifo_nempty || pend_q;
  assign w_pop         = w_valid && bus.i_weight_ready;
  assign w_pop_fifo    = w_pop && w_fifo_nempty;
  assign w_push        = pend_q && !(w_pop && !w_fifo_nempty);
  assign w_occ_next    = count_q + {1'b0, pend_q} - {1'b0, w_pop};
  assign w_abort       = i_abort && (state_q != S_IDLE);
  assign w_issue       = (state_q == S_ISSUE) && !i_abort && (w_occ_next < 2'd2);
  assign w_next_layer  = next_layer(mask_q, layer_q);
  assign w_layer_last  = (layer_q == c_L1) ? c_LAST_L1 :
                         (layer_q == c_L2) ? c_LAST_L2 : c_LAST_L3;

  always_comb begin
    w_head_layer = fifo_layer_q[rd_ptr_q];
    w_head_addr  = fifo_addr_q[rd_ptr_q];
    w_head_data  = fifo_data_q[rd_ptr_q];
    if (!w_fifo_nempty && pend_q) begin
      w_head_layer = pend_layer_q;
      w_head_addr  = pend_addr_q;
      w_head_data  = bus.i_mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      layer_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      layer_q <= layer_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    layer_d = layer_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mask_d  = i_layer_mask;
          layer_d = next_layer(i_layer_mask, {LAYER_WIDTH{1'b0}});
          addr_d  = '0;
          state_d = (i_layer_mask == 3'b000) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_issue) begin
          if (addr_q == w_layer_last) begin
            addr_d  = '0;
            layer_d = w_next_layer;
            if (w_next_layer == {LAYER_WIDTH{1'b0}}) state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + WEIGHT_COUNTER_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (w_occ_next == 2'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_layer_q <= '0;
      pend_addr_q  <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_layer_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
        fifo_data_q[i]  <= '0;
      end
    end else if (w_abort) begin
      pend_q   <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pend_q <= w_issue;
      if (w_issue) begin
        pend_layer_q <= layer_q;
        pend_addr_q  <= addr_q;
      end
      if (w_push) begin
        fifo_layer_q[wr_ptr_q] <= pend_layer_q;
        fifo_addr_q[wr_ptr_q]  <= pend_addr_q;
        fifo_data_q[wr_ptr_q]  <= bus.i_mem_data;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (w_pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop_fifo};
    end
  end

  assign bus.o_mem_rd_en    = w_issue;
  assign bus.o_mem_layer    = layer_q;
  assign bus.o_mem_addr     = addr_q;
  assign bus.o_weight_valid = w_valid;
  assign bus.o_weight_layer = w_head_layer;
  assign bus.o_weight_addr  = w_head_addr;
  assign bus.o_weight       = w_head_data;
  assign o_busy             = (state_q != S_IDLE);
  assign o_done             = (state_q == S_DONE);

endmodule
`default_nettype wire
